// File: rtl/tx_share_arbiter.sv
// -----------------------------------------------------------------------------
// tx_share_arbiter
//
// Shares one serial byte transmitter among NREQ byte producers. A round-robin
// arbiter picks a requester while the FSM is idle and the link is ready. The
// FSM then runs the transmitter handshake: load strobe, send strobe, then a
// wait for tx_end. A watchdog aborts a transfer whose tx_end never arrives.
// All outputs are registered.
//
// Optional feature macro: FIXED_PRI0_EN
//   defined   : requester 0 always wins when requesting; the others share
//               round-robin, and rr_ptr is left alone after a requester-0
//               transfer.
//   undefined : pure round-robin.
//
// Ports
//   clock         in   rising-edge clock
//   reset_n       in   asynchronous reset, active low
//   req           in   [NREQ]   per-requester request level, held until gnt
//   data_in       in   [NREQ*DATA_W] requester i byte at [i*DATA_W +: DATA_W]
//   gnt           out  [NREQ]   one-hot 1-cycle grant; byte captured that cycle
//   done          out  [NREQ]   one-hot 1-cycle completion pulse
//   err           out  [NREQ]   one-hot 1-cycle timeout pulse
//   dsr           in   link ready; new grants only while high
//   tx_load       out  1-cycle load strobe to transmitter
//   tx_data       out  [DATA_W] byte to transmitter, held until next grant
//   tx_send       out  1-cycle send strobe
//   tx_end        in   transmitter frame-complete pulse
//   busy          out  high whenever the FSM is not idle
//   timeout_flag  out  sticky timeout indicator, cleared only by reset
//
// Handshake: a requester holds req until it sees its gnt pulse; the byte on
// its data_in lane is captured in the cycle the grant is issued, so the lane
// may change from the cycle after gnt onward.
// -----------------------------------------------------------------------------
module tx_share_arbiter #(
    parameter int NREQ    = 4,
    parameter int DATA_W  = 8,
    parameter int TIMEOUT = 2047
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic [NREQ-1:0]          req,
    input  logic [NREQ*DATA_W-1:0]   data_in,
    output logic [NREQ-1:0]          gnt,
    output logic [NREQ-1:0]          done,
    output logic [NREQ-1:0]          err,
    input  logic                     dsr,
    output logic                     tx_load,
    output logic [DATA_W-1:0]        tx_data,
    output logic                     tx_send,
    input  logic                     tx_end,
    output logic                     busy,
    output logic                     timeout_flag
);

    localparam int PTR_W = $clog2(NREQ);
    localparam int SW    = PTR_W + 1;          // wide enough for rr_ptr + i
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        LOAD     = 2'd1,
        SEND     = 2'd2,
        WAIT_END = 2'd3
    } state_t;

    state_t             state, state_nxt;
    logic [PTR_W-1:0]   rr_ptr, rr_nxt;
    logic [PTR_W-1:0]   owner, owner_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic [NREQ-1:0]    gnt_nxt, done_nxt, err_nxt;
    logic               load_nxt, send_nxt, busy_nxt, tflag_nxt;
    logic [DATA_W-1:0]  data_nxt;

    // Arbitration results
    logic [NREQ-1:0]    req_rr;
    logic               win_found;
    logic [PTR_W-1:0]   win_idx;
    logic [SW-1:0]      sum;
    logic [PTR_W-1:0]   owner_inc;
    logic [PTR_W-1:0]   rr_after;

    // Round-robin search: first set request at or above rr_ptr, with wrap.
    always_comb begin
        req_rr = req;
`ifdef FIXED_PRI0_EN
        // Requester 0 is handled by the fixed-priority override below.
        req_rr[0] = 1'b0;
`endif
        win_found = 1'b0;
        win_idx   = '0;
        sum       = '0;
        for (int i = 0; i < NREQ; i++) begin
            sum = {1'b0, rr_ptr} + SW'(i);
            if (sum >= SW'(NREQ)) begin
                sum = sum - SW'(NREQ);
            end
            if (!win_found && req_rr[sum[PTR_W-1:0]]) begin
                win_found = 1'b1;
                win_idx   = sum[PTR_W-1:0];
            end
        end
`ifdef FIXED_PRI0_EN
        if (req[0]) begin
            win_found = 1'b1;
            win_idx   = '0;
        end
`endif
    end

    // Pointer value after the current owner finishes (done or timeout).
    always_comb begin
        owner_inc = (owner == PTR_W'(NREQ - 1)) ? '0 : owner + 1'b1;
`ifdef FIXED_PRI0_EN
        rr_after  = (owner == '0) ? rr_ptr : owner_inc;
`else
        rr_after  = owner_inc;
`endif
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_nxt = state;
        rr_nxt    = rr_ptr;
        owner_nxt = owner;
        cnt_nxt   = cnt;
        gnt_nxt   = '0;
        done_nxt  = '0;
        err_nxt   = '0;
        load_nxt  = 1'b0;
        send_nxt  = 1'b0;
        data_nxt  = tx_data;
        tflag_nxt = timeout_flag;

        case (state)
            IDLE: begin
                if (dsr && win_found) begin
                    gnt_nxt[win_idx] = 1'b1;
                    data_nxt         = data_in[win_idx*DATA_W +: DATA_W];
                    load_nxt         = 1'b1;
                    owner_nxt        = win_idx;
                    state_nxt        = LOAD;
                end
            end
            LOAD: begin
                send_nxt  = 1'b1;
                state_nxt = SEND;
            end
            SEND: begin
                cnt_nxt   = '0;
                state_nxt = WAIT_END;
            end
            WAIT_END: begin
                // tx_end takes precedence over a coinciding timeout.
                if (tx_end) begin
                    done_nxt[owner] = 1'b1;
                    rr_nxt          = rr_after;
                    state_nxt       = IDLE;
                end else if (cnt == CNT_W'(TIMEOUT)) begin
                    err_nxt[owner]  = 1'b1;
                    tflag_nxt       = 1'b1;
                    rr_nxt          = rr_after;
                    state_nxt       = IDLE;
                end else begin
                    // Exits at TIMEOUT, so the counter can never wrap.
                    cnt_nxt = cnt + 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        busy_nxt = (state_nxt != IDLE);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            rr_ptr       <= '0;
            owner        <= '0;
            cnt          <= '0;
            gnt          <= '0;
            done         <= '0;
            err          <= '0;
            tx_load      <= 1'b0;
            tx_send      <= 1'b0;
            tx_data      <= '0;
            busy         <= 1'b0;
            timeout_flag <= 1'b0;
        end else begin
            state        <= state_nxt;
            rr_ptr       <= rr_nxt;
            owner        <= owner_nxt;
            cnt          <= cnt_nxt;
            gnt          <= gnt_nxt;
            done         <= done_nxt;
            err          <= err_nxt;
            tx_load      <= load_nxt;
            tx_send      <= send_nxt;
            tx_data      <= data_nxt;
            busy         <= busy_nxt;
            timeout_flag <= tflag_nxt;
        end
    end

endmodule

// File: tb/tb_tx_share_arbiter.sv
// -----------------------------------------------------------------------------
// tb_tx_share_arbiter
//
// Directed plus randomized bench for tx_share_arbiter (NREQ=4, DATA_W=8,
// TIMEOUT=31). A small reference model tracks the round-robin pointer and
// the sticky timeout flag; a queue holds the bytes expected on tx_data.
// Inputs change 1 time unit after the rising edge and outputs are sampled
// at that same point.
// -----------------------------------------------------------------------------
module tb_tx_share_arbiter;

    localparam int NREQ   = 4;
    localparam int DATA_W = 8;
    localparam int TO     = 31;

    logic                   clock;
    logic                   reset_n;
    logic [NREQ-1:0]        req;
    logic [NREQ*DATA_W-1:0] data_in;
    logic [NREQ-1:0]        gnt, done, err;
    logic                   dsr;
    logic                   tx_load, tx_send, tx_end;
    logic [DATA_W-1:0]      tx_data;
    logic                   busy, timeout_flag;

    tx_share_arbiter #(.NREQ(NREQ), .DATA_W(DATA_W), .TIMEOUT(TO)) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .req          (req),
        .data_in      (data_in),
        .gnt          (gnt),
        .done         (done),
        .err          (err),
        .dsr          (dsr),
        .tx_load      (tx_load),
        .tx_data      (tx_data),
        .tx_send      (tx_send),
        .tx_end       (tx_end),
        .busy         (busy),
        .timeout_flag (timeout_flag)
    );

    // ---------------- clock ----------------
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // ---------------- scoreboard / model state ----------------
    int checks = 0;
    int errors = 0;
    logic [DATA_W-1:0] exp_q[$];   // bytes expected on tx_data at each grant
    int m_rr    = 0;               // model round-robin pointer
    bit m_tflag = 1'b0;            // model sticky timeout flag

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Winner per the arbitration rules, from the model pointer.
    function automatic int model_win(input logic [NREQ-1:0] r);
`ifdef FIXED_PRI0_EN
        if (r[0]) return 0;
`endif
        for (int i = 0; i < NREQ; i++) begin
            int c;
            c = (m_rr + i) % NREQ;
`ifdef FIXED_PRI0_EN
            if (c == 0) continue;
`endif
            if (r[c]) return c;
        end
        return -1;
    endfunction

    function automatic logic [NREQ*DATA_W-1:0] rand_data();
        logic [NREQ*DATA_W-1:0] v;
        for (int i = 0; i < NREQ; i++) v[i*DATA_W +: DATA_W] = DATA_W'($urandom);
        return v;
    endfunction

    // One complete transfer starting from IDLE with req=r presented.
    //   d    : WAIT_END cycle index (0-based) in which tx_end is pulsed
    //   hang : never pulse tx_end (watchdog expires)
    //   keep : winner keeps its req high after gnt
    //   spur : pulse tx_end during LOAD and SEND (must be ignored)
    task automatic do_xfer(input logic [NREQ-1:0] r, input logic [NREQ*DATA_W-1:0] dv,
                           input int d, input bit hang, input bit keep, input bit spur,
                           output int w);
        bit fired;
        data_in = dv;
        req     = r;
        dsr     = 1'b1;
        w       = model_win(r);
        exp_q.push_back(dv[w*DATA_W +: DATA_W]);
        tick();
        chk("gnt", gnt, 32'(1) << w);
        chk("tx_load", tx_load, 1);
        chk("tx_data", tx_data, exp_q.pop_front());
        chk("busy_load", busy, 1);
        req     = keep ? r : (r & ~(NREQ'(1) << w));
        data_in = rand_data();
        dsr     = 1'($urandom_range(0, 1));   // must not disturb the transfer
        tx_end  = spur;
        tick();
        tx_end  = 1'b0;
        chk("tx_send", tx_send, 1);
        chk("gnt_clear", gnt, 0);
        tx_end  = spur;
        tick();
        tx_end  = 1'b0;
        chk("send_clear", {tx_send, tx_load, done}, 0);
        for (int k = 0; k <= TO; k++) begin
            fired  = !hang && (k == d);
            tx_end = fired;
            tick();
            tx_end = 1'b0;
            if (fired) begin
                chk("done", done, 32'(1) << w);
                chk("no_err", err, 0);
                chk("busy_done", busy, 0);
                break;
            end else if (k == TO) begin
                m_tflag = 1'b1;
                chk("err", err, 32'(1) << w);
                chk("no_done", done, 0);
                chk("busy_err", busy, 0);
            end else begin
                chk("wait_quiet", {done, err, busy}, 1);
            end
        end
        chk("timeout_flag", timeout_flag, m_tflag);
`ifdef FIXED_PRI0_EN
        if (w != 0) m_rr = (w + 1) % NREQ;
`else
        m_rr = (w + 1) % NREQ;
`endif
        dsr = 1'b1;
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        int w;
        logic [NREQ-1:0] pend;
        logic [NREQ*DATA_W-1:0] dv;

        reset_n = 1'b0;
        req     = '0;
        data_in = '0;
        dsr     = 1'b0;
        tx_end  = 1'b0;
        #12;
        chk("rst_pulses", {gnt, done, err}, 0);
        chk("rst_strobes", {tx_load, tx_send, busy, timeout_flag}, 0);
        chk("rst_tx_data", tx_data, 0);
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        tick();

        // Single requester 0, byte A5
        dv = rand_data();
        dv[DATA_W-1:0] = 8'hA5;
        do_xfer(4'b0001, dv, 3, 0, 0, 0, w);

        // Watchdog: requester 2 alone, transmitter hangs
        do_xfer(4'b0100, rand_data(), 0, 1, 0, 0, w);
        // Next grant goes to requester 3 with everyone requesting
        do_xfer(4'b1111, rand_data(), 4, 0, 0, 0, w);
        chk("after_timeout_owner", w, 3);

        // tx_end coincides with the timeout: done only, flag unchanged
        do_xfer(4'b0010, rand_data(), TO, 0, 0, 1, w);

        // Reset asserted during WAIT_END
        req = 4'b0010;
        dsr = 1'b1;
        tick();
        req = '0;
        tick();
        tick();
        tick();
        tick();
        #2;
        reset_n = 1'b0;
        #1;
        chk("async_rst_pulses", {gnt, done, err}, 0);
        chk("async_rst_flags", {tx_load, tx_send, busy, timeout_flag}, 0);
        chk("async_rst_data", tx_data, 0);
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        m_rr    = 0;
        m_tflag = 1'b0;
        exp_q.delete();
        tick();

        // All four requesting and holding: order from reset is 0,1,2,3,0
        for (int n = 0; n < 5; n++) begin
            do_xfer(4'b1111, rand_data(), 5, 0, 1, 0, w);
            chk("rr_order", w, n % NREQ);
        end

        // dsr low blocks grants
        req = 4'b0010;
        dsr = 1'b0;
        for (int n = 0; n < 50; n++) begin
            tick();
            chk("dsr_block", {gnt, busy}, 0);
        end
        do_xfer(4'b0010, rand_data(), 2, 0, 0, 0, w);

        // Withdrawn request and stray tx_end while idle
        req = 4'b0100;
        dsr = 1'b0;
        tick();
        tick();
        req = '0;
        dsr = 1'b1;
        for (int n = 0; n < 8; n++) begin
            tx_end = (n == 3);
            tick();
            tx_end = 1'b0;
            chk("withdrawn", {gnt, done, err, busy, tx_load}, 0);
        end

`ifdef FIXED_PRI0_EN
        do_xfer(4'b1110, rand_data(), 3, 0, 1, 0, w);
        do_xfer(4'b1111, rand_data(), 3, 0, 0, 0, w);
        chk("pri0_wins", w, 0);
        do_xfer(4'b1110, rand_data(), 3, 0, 0, 0, w);
`endif

        // Randomized traffic
        pend = '0;
        for (int n = 0; n < 60; n++) begin
            int  d;
            bit  hang, keep, spur;
            pend = pend | NREQ'($urandom_range(0, (1 << NREQ) - 1));
            if (pend == '0) pend[$urandom_range(0, NREQ - 1)] = 1'b1;
            d    = ($urandom_range(0, 7) == 0) ? $urandom_range(TO - 1, TO) : $urandom_range(0, 10);
            hang = ($urandom_range(0, 9) == 0);
            keep = ($urandom_range(0, 3) == 0);
            spur = 1'($urandom_range(0, 1));
            do_xfer(pend, rand_data(), d, hang, keep, spur, w);
            if (!keep) pend[w] = 1'b0;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/tx_share_arbiter.md
Name: tx_share_arbiter

Overview:
Round-robin arbiter and sequencer that shares the single serial byte transmitter among NREQ byte producers, such as the channel-scan sampler and the status/command source. It runs the transmitter's load -> send -> wait-for-tx_end handshake for each granted byte and returns per-requester completion or error pulses. It also gates new grants on dsr and guards against a hung transmitter with a timeout watchdog.

Parameters:
NREQ, 4, number of requesters (2..8)
DATA_W, 8, byte width per requester
TIMEOUT, 2047, max cycles in WAIT_END before abort (>=16)

Ports:
clock  in  1  rising-edge clock
reset_n  in  1  asynchronous reset, active low
req  in  NREQ  per-requester request level; held until gnt
data_in  in  NREQ*DATA_W  requester i byte at [i*DATA_W +: DATA_W]
gnt  out  NREQ  one-hot, 1-cycle grant pulse; data captured that cycle
done  out  NREQ  one-hot, 1-cycle completion pulse
err  out  NREQ  one-hot, 1-cycle timeout pulse to granted requester
dsr  in  1  link ready; no new grant while low
tx_load  out  1  1-cycle load strobe to transmitter
tx_data  out  DATA_W  byte to transmitter, stable from tx_load until next grant
tx_send  out  1  1-cycle send strobe
tx_end  in  1  transmitter frame-complete pulse
busy  out  1  high in any state except IDLE
timeout_flag  out  1  sticky; set on any timeout, cleared only by reset

Behaviour:
- Reset (async, reset_n=0): state IDLE; gnt, done, err, tx_load, tx_send, busy and timeout_flag = 0; tx_data = 0; rr_ptr = 0; wait counter = 0; owner = 0.
- All outputs are registered.
- FSM states: IDLE, LOAD, SEND, WAIT_END.
- IDLE:
  - If dsr=1 and req!=0, pick the winner w as the first set req index searching upward from rr_ptr with wrap.
  - At the next edge: gnt[w]=1, tx_data=data_in[w], tx_load=1, owner=w, state=LOAD.
  - Otherwise remain in IDLE.
- LOAD, one cycle: tx_send=1, state=SEND.
- SEND, one cycle: clear the counter, state=WAIT_END.
- WAIT_END:
  - Counter increments each cycle.
  - If tx_end=1: done[owner]=1, rr_ptr=(owner+1) mod NREQ, state=IDLE.
  - Else if counter==TIMEOUT: err[owner]=1, timeout_flag=1, rr_ptr=(owner+1) mod NREQ, state=IDLE.
  - If tx_end and the timeout coincide, tx_end wins: done only, no err.
- Latency:
  - req sampled in cycle t → gnt and tx_load in t+1 → tx_send in t+2 → WAIT_END from t+3.
  - Minimum grant-to-grant spacing is 4 cycles plus the transmitter time.
- tx_end outside WAIT_END is ignored.
- dsr changes after a grant do not abort the transfer; dsr is checked only in IDLE.
- If a requester drops req before gnt, the request is withdrawn with no pulse.
- A granted requester keeping req high is re-arbitrated fairly; it wins again only if no other req is set.
- Counter width is clog2(TIMEOUT+1); it never wraps.
- rr_ptr wraps from NREQ-1 to 0.

Optional Feature:
FIXED_PRI0_EN
- Defined: requester 0 always wins when req[0]=1, regardless of rr_ptr. Other requesters use round-robin among themselves. rr_ptr is not advanced after a requester-0 transfer.
- Undefined: pure round-robin as described above.

Test Plan:
1. Reset with req=4'b0001, dsr=1, data_in[0]=8'hA5 → gnt=0001 at t+1 with tx_load=1 and tx_data=A5; tx_send at t+2; tx_end pulse → done=0001 next cycle, busy=0.
2. req=4'b1111 held, tx_end returned 5 cycles after send each time → grant order 0,1,2,3,0; done pulses match that order.
3. dsr=0 with req=0010 → no gnt for 50 cycles. Raise dsr → gnt=0010 next cycle.
4. TIMEOUT=31, grant requester 2, tx_end never asserted → err=0100 exactly 32 cycles after WAIT_END entry; timeout_flag=1 and stays 1; next grant goes to requester 3.
5. tx_end coincides with counter==TIMEOUT → done pulse only, err=0, timeout_flag unchanged. Separately, reset_n=0 during WAIT_END → all outputs 0 immediately, state IDLE.
6. FIXED_PRI0_EN defined, req=1110 then req[0] raised mid-transfer → requester 0 gets the next grant, then round-robin resumes at the prior rr_ptr.
